queue_rtl: RTL

Parameterized synchronous FIFO queue with valid/ready handshakes on both ends: producers write on the enqueue side and consumers read on the dequeue side. It is the two-ended counterpart of the single-entry enabled register, and decouples TinyRV1 pipeline stages from memory and I/O interfaces. Storage is a circular buffer addressed by read and write pointers. There is no combinational path from either input handshake to the opposite side.

---
 rtl/queue_rtl.sv | 57 +++++
 1 files changed

// File: rtl/queue_rtl.sv
// Parameterized circular-buffer FIFO with valid/ready on both ends.
// Handshake outputs depend only on registered state; no bypass paths.
module queue_rtl #(
    parameter int p_nbits = 8,
    parameter int p_depth = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enq_val,
    output logic                         enq_rdy,
    input  logic [p_nbits-1:0]           enq_msg,
    output logic                         deq_val,
    input  logic                         deq_rdy,
    output logic [p_nbits-1:0]           deq_msg,
    output logic [$clog2(p_depth+1)-1:0] count
);

    localparam int CW = $clog2(p_depth + 1);
    localparam int PW = $clog2(p_depth);
    localparam logic [CW-1:0] FULL = CW'(p_depth);

    logic [p_nbits-1:0] storage [p_depth];
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic               enq_fire;
    logic               deq_fire;

    assign enq_rdy  = (count != FULL);
    assign deq_val  = (count != '0);
    assign deq_msg  = storage[rptr];
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            storage <= '{default: '0};
        end else begin
            if (enq_fire) begin
                storage[wptr] <= enq_msg;
                wptr          <= wptr + PW'(1);
            end
            if (deq_fire) begin
                rptr <= rptr + PW'(1);
            end
            if (enq_fire && !deq_fire) begin
                count <= count + CW'(1);
            end else if (deq_fire && !enq_fire) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
